// File: rtl/par_mult_pkg.sv
// Shared types for the fifomult receiver.
// DATA_W/RES_W: operand and product widths; in_state_t: operand-pairing FSM states;
// result_t: one queued FIFO entry (product plus bad-parity flag); parity16: XOR reduce.
package par_mult_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RES_W  = 32;

  typedef enum logic {WAIT_A, WAIT_B} in_state_t;

  typedef struct packed {
    logic [RES_W-1:0] product;
    logic             err;
  } result_t;

  function automatic logic parity16(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/par_mult_fifo.sv
// Synchronous result FIFO.
// Ports: clk/rst (sync active-high), push_i/wdata_i write side, pop_i/rdata_o read side
// (rdata_o shows the head entry combinationally), count_o occupancy, count_next_o occupancy
// after this edge, empty_o/full_o status.
module par_mult_fifo
  import par_mult_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned AddrW     = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW      = AddrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  result_t         wdata_i,
  input  logic            pop_i,
  output result_t         rdata_o,
  output logic [CntW-1:0] count_o,
  output logic [CntW-1:0] count_next_o,
  output logic            empty_o,
  output logic            full_o
);

  result_t          mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  always_comb begin
    count_next_o = count_q + CntW'(push_i) - CntW'(pop_i);
    count_o      = count_q;
    empty_o      = (count_q == '0);
    full_o       = (count_q == CntW'(FIFO_DEPTH));
    rdata_o      = mem_q[rptr_q];
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_next_o;
    end
  end

  // Storage needs no reset: the count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  underflow_a: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/par_mult_core.sv
// Receiver end of the fifomult word protocol: pairs parity-protected signed operands A then B,
// multiplies them, queues results and drains them no faster than one per OUT_INTERVAL cycles.
// Ports: clk, rst (sync active-high); data_in/data_in_parity/data_in_valid operand stream;
// busy_out back-pressure; data_out/data_out_parity/data_out_valid paced result strobe;
// data_in_parity_error marks a strobed result that came from a bad-parity pair.
module par_mult_core
  import par_mult_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned OUT_INTERVAL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_parity,
  input  logic              data_in_valid,
  output logic              busy_out,
  output logic [RES_W-1:0]  data_out,
  output logic              data_out_parity,
  output logic              data_out_valid,
  output logic              data_in_parity_error
);

  localparam int unsigned     CntW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned     GapW      = (OUT_INTERVAL > 1) ? $clog2(OUT_INTERVAL) : 1;
  localparam logic [GapW-1:0] GapReload = GapW'(OUT_INTERVAL - 1);
  localparam logic [CntW-1:0] BusyLevel = CntW'(FIFO_DEPTH - 1);

  in_state_t         state_q;
  logic [DATA_W-1:0] a_q;
  logic              err_a_q;
  logic              push_q;
  result_t           push_data_q;
  logic [GapW-1:0]   gap_q;
  logic              busy_q;
  logic [RES_W-1:0]  data_out_q;
  logic              parity_q, valid_q, err_q;

  logic                    accept, err_in, pop, pair_err;
  logic signed [RES_W-1:0] a_ext, b_ext, product;
  result_t                 fifo_rdata;
  logic [CntW-1:0]         fifo_count, fifo_count_next;
  logic                    fifo_empty, fifo_full;

  always_comb begin
    accept   = data_in_valid & ~busy_q;
    err_in   = (data_in_parity != parity16(data_in));
    pair_err = err_a_q | err_in;
    pop      = (gap_q == '0) & ~fifo_empty;
    a_ext    = $signed({{(RES_W-DATA_W){a_q[DATA_W-1]}}, a_q});
    b_ext    = $signed({{(RES_W-DATA_W){data_in[DATA_W-1]}}, data_in});
    product  = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_A;
      a_q         <= '0;
      err_a_q     <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      data_out_q  <= '0;
      parity_q    <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      push_q <= 1'b0;
      // Threshold one below full leaves room for the push already in flight.
      busy_q <= (fifo_count_next >= BusyLevel);

      if (accept) begin
        case (state_q)
          WAIT_A: begin
            a_q     <= data_in;
            err_a_q <= err_in;
            state_q <= WAIT_B;
          end
          WAIT_B: begin
            push_q              <= 1'b1;
            push_data_q.err     <= pair_err;
            push_data_q.product <= pair_err ? '0 : product;
            state_q             <= WAIT_A;
          end
          default: state_q <= WAIT_A;
        endcase
      end

      if (pop) begin
        gap_q      <= GapReload;
        valid_q    <= 1'b1;
        data_out_q <= fifo_rdata.product;
        parity_q   <= ^fifo_rdata.product;
        err_q      <= fifo_rdata.err;
      end else begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        if (gap_q != '0) gap_q <= gap_q - 1'b1;
      end
    end
  end

  par_mult_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_q),
    .wdata_i     (push_data_q),
    .pop_i       (pop),
    .rdata_o     (fifo_rdata),
    .count_o     (fifo_count),
    .count_next_o(fifo_count_next),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push_q && fifo_full && !pop));

  assign busy_out             = busy_q;
  assign data_out             = data_out_q;
  assign data_out_parity      = parity_q;
  assign data_out_valid       = valid_q;
  assign data_in_parity_error = err_q;

endmodule

// File: tb/tb_par_mult_core.sv
// Scoreboard bench for par_mult_core: the driver pushes expected results computed with plain
// arithmetic; a monitor pops and compares on every data_out_valid strobe.
module tb_par_mult_core;

  localparam int FIFO_DEPTH   = 8;
  localparam int OUT_INTERVAL = 4;

  typedef struct {
    logic [31:0] prod;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        data_in_parity = 1'b0;
  logic        data_in_valid = 1'b0;
  logic        busy_out;
  logic [31:0] data_out;
  logic        data_out_parity, data_out_valid, data_in_parity_error;

  par_mult_core #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .OUT_INTERVAL(OUT_INTERVAL)
  ) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .data_in             (data_in),
    .data_in_parity      (data_in_parity),
    .data_in_valid       (data_in_valid),
    .busy_out            (busy_out),
    .data_out            (data_out),
    .data_out_parity     (data_out_parity),
    .data_out_valid      (data_out_valid),
    .data_in_parity_error(data_in_parity_error)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        have_a = 1'b0;
  logic [15:0] a_word;
  logic        a_err;
  int          max_count = 0;
  logic        saw_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: pair words, flag bad parity, product as wide integer arithmetic.
  task automatic model_accept(input logic [15:0] w, input logic p);
    logic   e;
    longint pa, pb, pr;
    exp_t   x;
    e = (p != ^w);
    if (!have_a) begin
      a_word = w;
      a_err  = e;
      have_a = 1'b1;
    end else begin
      pa = longint'($signed(a_word));
      pb = longint'($signed(w));
      pr = pa * pb;
      x.err  = a_err | e;
      x.prod = x.err ? 32'h0 : pr[31:0];
      exp_q.push_back(x);
      have_a = 1'b0;
    end
  endtask

  // Present a word until accepted; busy_out is stable between negedge and the next posedge.
  task automatic send_word(input logic [15:0] w, input logic p);
    logic accepted;
    int   tries;
    accepted = 1'b0;
    tries    = 0;
    while (!accepted) begin
      @(negedge clk);
      data_in        = w;
      data_in_parity = p;
      data_in_valid  = 1'b1;
      if (!busy_out) begin
        accepted = 1'b1;
        model_accept(w, p);
      end
      @(posedge clk);
      tries++;
      if (!accepted && tries > 500) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got busy for %0d cycles, required acceptance", tries);
        accepted = 1'b1;
      end
    end
  endtask

  task automatic send_pair(input logic [15:0] a, input logic pa, input logic [15:0] b,
                           input logic pb);
    send_word(a, pa);
    send_word(b, pb);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    data_in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    data_in_valid = 1'b0;
    exp_q.delete();
    have_a = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", data_out_valid, 0);
    check("rst_busy", busy_out, 0);
    check("rst_data", data_out, 0);
    check("rst_err", data_in_parity_error, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (OUT_INTERVAL + 2) @(posedge clk);
  endtask

  // Monitor: scoreboard pop on strobes plus per-cycle invariants.
  initial begin : monitor
    int   cyc;
    int   last;
    logic pp_flag;
    exp_t x;
    cyc     = 0;
    last    = -1000;
    pp_flag = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        last    = -1000;
        pp_flag = 1'b0;
      end else begin
        if (data_out_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got data_out 0x%0h, required no strobe", data_out);
          end else begin
            x = exp_q.pop_front();
            check("data_out", data_out, x.prod);
            check("data_out_parity", data_out_parity, ^x.prod);
            check("parity_error", data_in_parity_error, x.err);
          end
          check("strobe_spacing_ok", (cyc - last) >= OUT_INTERVAL, 1);
          last = cyc;
        end else begin
          check("err_idle", data_in_parity_error, 0);
        end
        check("busy_level", busy_out, u_dut.fifo_count >= 4'(FIFO_DEPTH - 1));
        if (busy_out) saw_busy = 1'b1;
        if (int'(u_dut.fifo_count) > max_count) max_count = int'(u_dut.fifo_count);
        if (pp_flag) begin
          check("pushpop_count", u_dut.fifo_count, 6);
          check("pushpop_busy", busy_out, 0);
          pp_flag = 1'b0;
        end
      end
      @(negedge clk);
      pp_flag = u_dut.push_q && u_dut.pop && (u_dut.fifo_count == 4'd6);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish, required completion within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] w;
    logic        bad;
    repeat (2) @(posedge clk);
    #1;
    check("init_valid", data_out_valid, 0);
    check("init_busy", busy_out, 0);
    check("init_data", data_out, 0);
    check("init_parity", data_out_parity, 0);
    check("init_err", data_in_parity_error, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: basic pair and latency
    send_pair(16'h0003, 1'b0, 16'hFFFE, 1'b1);
    #1;
    check("lat_t0", data_out_valid, 0);
    @(negedge clk);
    data_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("lat_t1", data_out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_t2", data_out_valid, 1);
    check("lat_data", data_out, 32'hFFFF_FFFA);
    wait_drain();

    // 2: signed corners
    send_pair(16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
    send_pair(16'h8000, 1'b1, 16'h8000, 1'b1);
    send_pair(16'h8000, 1'b1, 16'h7FFF, 1'b1);
    idle(1);
    wait_drain();

    // 3: bad parity on A, then a good pair
    send_pair(16'h1234, 1'b0, 16'h0002, 1'b1);
    send_pair(16'h0002, 1'b1, 16'h0002, 1'b1);
    idle(1);
    wait_drain();

    // 4: continuous traffic to reach back-pressure
    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      send_word(w, ^w);
    end
    idle(1);
    wait_drain();
    check("busy_seen", saw_busy, 1);

    // 5: reset mid-pair, then reset with results queued
    send_word(16'h0005, 1'b1);
    do_reset();
    send_pair(16'h0002, 1'b1, 16'h0003, 1'b0);
    idle(1);
    wait_drain();
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      send_pair(w, ^w, 16'h0011, 1'b0);
    end
    do_reset();
    idle(20);
    check("post_reset_busy", busy_out, 0);

    // Mixed random traffic with occasional bad parity and gaps
    for (int i = 0; i < 80; i++) begin
      w   = 16'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send_word(w, (^w) ^ bad);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    wait_drain();

    check("no_overflow", max_count <= FIFO_DEPTH - 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
